uart_sdram_bridge: RTL and testbench
====================================

// Module: uart_sdram_bridge
// PURPOSE
//  Parametrised UART-byte-stream to SDRAM command bridge; successor of the single-direction frame parser.
//  Parses 'R'/'W' frames from the UART RX byte stream and issues one SDRAM access per word with auto-increment address.
//  Adds a TX byte path: read data and a frame status byte go back to the host.
//  Sits between the UART core (rx/tx byte handshakes) and the SDRAM controller user port.
// PARAMETERS
//  ADR_BYTES   3       address bytes per frame, MSB first; ADR_W = 8*ADR_BYTES
//  DATA_BYTES  2       bytes per SDRAM word, MSB first; DW = 8*DATA_BYTES
//  LEN_BYTES   2       word-count bytes, MSB first; LEN_W = 8*LEN_BYTES
//  TIMEOUT     16'hEEEE  CLK cycles without rx_stb before an open frame aborts
// PORTS
//  CLK        in   1       clock, all logic on rising edge
//  RST        in   1       synchronous reset, active high
//  rx_data    in   8       received byte
//  rx_stb     in   1       rx_data valid
//  rx_ack     out  1       byte consumed this cycle (combinational)
//  tx_data    out  8       byte to transmit
//  tx_stb     out  1       tx_data valid, held until tx_ack
//  tx_ack     in   1       UART TX accepted byte
//  sd_adr     out  ADR_W   SDRAM word address
//  sd_wdata   out  DW      SDRAM write data
//  sd_stb_rd  out  1       read request, held until sd_ack
//  sd_stb_wt  out  1       write request, held until sd_ack
//  sd_ack     in   1       request done; sd_rdata valid same cycle on reads
//  sd_rdata   in   DW      SDRAM read data
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; tx_stb, sd_stb_rd, sd_stb_wt, busy = 0; sd_adr, sd_wdata, tx_data, length = 0. rx_ack forced 0 while RST.
//  Frame: cmd(0x52 'R' | 0x57 'W'), ADR_BYTES addr, LEN_BYTES len; W then carries len*DATA_BYTES data bytes.
//  rx_ack = rx_stb in IDLE/HDR_ADR/HDR_LEN/HDR_CSUM/RX_DATA, else 0 (backpressure). A byte is taken when rx_stb&rx_ack.
//  States: IDLE -> HDR_ADR -> HDR_LEN -> [HDR_CSUM] -> CHK -> {RX_DATA -> SD_REQ} | {SD_REQ -> TX_DATA} -> TX_STAT -> IDLE.
//  IDLE: non-command bytes acked and dropped; cmd byte latches op, -> HDR_ADR.
//  HDR_ADR/HDR_LEN: byte counters, shift MSB first; last byte -> next state.
//  CHK (1 cycle): len==0 -> TX_STAT ('K'); W -> RX_DATA; R -> SD_REQ.
//  RX_DATA: collect DATA_BYTES into sd_wdata, -> SD_REQ.
//  SD_REQ: strobe registered-high from entry; on sd_ack strobe drops next edge, sd_adr += 1 (mod 2^ADR_W, wraps silently),
//   len -= 1; R: latch sd_rdata, -> TX_DATA; W: len_remaining==0 -> TX_STAT else RX_DATA.
//  TX_DATA: DATA_BYTES bytes MSB first, each tx_stb held until tx_ack; then len==0 -> TX_STAT else SD_REQ.
//  TX_STAT: send 0x4B 'K' (ok), 0x45 'E' (timeout) or 0x4E 'N' (csum fail); on tx_ack -> IDLE.
//  Timeout: counter clears on each accepted byte and in states outside HDR_*/RX_DATA; reaching TIMEOUT in HDR_*/RX_DATA
//   -> TX_STAT with 'E'; words already written stay written. No timeout in SD_REQ/TX_*.
//  Simultaneous: timeout expiry and accepted rx byte in same cycle -> byte wins, counter clears.
//  Reset mid-operation: any strobe drops on the edge RST is sampled; pending frame discarded, no status sent.
// CONFIGURATION
//  UART_SDRAM_CSUM_EN defined: HDR_CSUM state takes one byte = XOR of cmd, address and length bytes;
//   mismatch -> TX_STAT 'N', no SDRAM access. Undefined: no HDR_CSUM state, HDR_LEN -> CHK, 'N' never sent.
// STRUCTURE
//  Package uart_sdram_pkg: state enum, CMD_RD=8'h52, CMD_WT=8'h57, ST_OK=8'h4B, ST_TMO=8'h45, ST_CSUM=8'h4E.
//  Sub-module uart_sdram_timeout: synchronous clear/enable counter, parameter TIMEOUT, flag output.
// TESTING
//  W, adr 000010, len 0002, data 1234 ABCD, sd_ack after 3 cycles -> writes 1234@000010, ABCD@000011, tx 'K'.
//  R, adr FFFFFF, len 0002, sd_rdata 5555 then AAAA -> reads at FFFFFF then 000000 (wrap), tx 55 55 AA AA 'K'.
//  W header then 1 data byte, rx idle TIMEOUT cycles -> no sd_stb_wt, tx 'E', busy 0 after tx_ack.
//  Junk 00 41 then R with len 0000 -> junk acked/dropped, no SDRAM strobe, tx 'K'.
//  RST pulsed mid-SD_REQ and mid-TX_DATA -> strobes 0 next edge, state IDLE, no status byte.
//  CSUM_EN: correct XOR -> normal transfer; wrong XOR -> no strobe, tx 'N'.

Source files
------------

// File: rtl/uart_sdram_pkg.sv
// Shared types and byte codes for the UART-to-SDRAM bridge.
package uart_sdram_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HDR_ADR,
    HDR_LEN,
    HDR_CSUM,
    CHK,
    RX_DATA,
    SD_REQ,
    TX_DATA,
    TX_STAT
  } state_t;

  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_WT  = 8'h57;
  localparam logic [7:0] ST_OK   = 8'h4B;
  localparam logic [7:0] ST_TMO  = 8'h45;
  localparam logic [7:0] ST_CSUM = 8'h4E;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_RD) || (b == CMD_WT);
  endfunction

endpackage

// File: rtl/uart_sdram_timeout.sv
// Idle-cycle counter: flag rises once TIMEOUT enabled cycles pass without a clear.
module uart_sdram_timeout #(
  parameter int TIMEOUT = 16'hEEEE
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic flag
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // Saturates at TIMEOUT so the flag stays up until the owner reacts.
  always_ff @(posedge CLK) begin
    if (RST || clr)
      cnt <= '0;
    else if (en && cnt != TW'(TIMEOUT))
      cnt <= cnt + 1'b1;
  end

  assign flag = en && (cnt == TW'(TIMEOUT));

endmodule

// File: rtl/uart_sdram_bridge.sv
// UART byte-stream to SDRAM bridge: parses R/W frames, one SDRAM access per word, returns read data plus a status byte.
// Define UART_SDRAM_CSUM_EN to require an XOR checksum byte after the frame header.
module uart_sdram_bridge
  import uart_sdram_pkg::*;
#(
  parameter int ADR_BYTES  = 3,
  parameter int DATA_BYTES = 2,
  parameter int LEN_BYTES  = 2,
  parameter int TIMEOUT    = 16'hEEEE,
  localparam int ADR_W = 8*ADR_BYTES,
  localparam int DW    = 8*DATA_BYTES,
  localparam int LEN_W = 8*LEN_BYTES
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       rx_data,
  input  logic             rx_stb,
  output logic             rx_ack,
  output logic [7:0]       tx_data,
  output logic             tx_stb,
  input  logic             tx_ack,
  output logic [ADR_W-1:0] sd_adr,
  output logic [DW-1:0]    sd_wdata,
  output logic             sd_stb_rd,
  output logic             sd_stb_wt,
  input  logic             sd_ack,
  input  logic [DW-1:0]    sd_rdata,
  output logic             busy
);
  localparam logic [7:0] ADR_LAST = 8'(ADR_BYTES - 1);
  localparam logic [7:0] LEN_LAST = 8'(LEN_BYTES - 1);
  localparam logic [7:0] DAT_LAST = 8'(DATA_BYTES - 1);

  state_t           state;
  logic             op_wr;
  logic [7:0]       byte_cnt;
  logic [LEN_W-1:0] len;
  logic [DW-1:0]    rd_shift;
  logic             take, tmo_en, tmo_clr, tmo_flag;
`ifdef UART_SDRAM_CSUM_EN
  logic [7:0]       csum;
`endif

  // Bytes are only accepted in parsing states; everything else backpressures the UART.
  assign rx_ack  = rx_stb && !RST &&
                   (state inside {IDLE, HDR_ADR, HDR_LEN, HDR_CSUM, RX_DATA});
  assign take    = rx_ack;
  assign tmo_en  = state inside {HDR_ADR, HDR_LEN, HDR_CSUM, RX_DATA};
  assign tmo_clr = take || !tmo_en;

  uart_sdram_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (tmo_clr),
    .en   (tmo_en),
    .flag (tmo_flag)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      byte_cnt  <= '0;
      len       <= '0;
      rd_shift  <= '0;
      sd_adr    <= '0;
      sd_wdata  <= '0;
      sd_stb_rd <= 1'b0;
      sd_stb_wt <= 1'b0;
      tx_data   <= '0;
      tx_stb    <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_SDRAM_CSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take && is_cmd(rx_data)) begin
            op_wr    <= (rx_data == CMD_WT);
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= HDR_ADR;
`ifdef UART_SDRAM_CSUM_EN
            csum     <= rx_data;
`endif
          end
        end

        HDR_ADR: begin
          if (take) begin
            sd_adr <= (sd_adr << 8) | ADR_W'(rx_data);
`ifdef UART_SDRAM_CSUM_EN
            csum   <= csum ^ rx_data;
`endif
            if (byte_cnt == ADR_LAST) begin
              byte_cnt <= '0;
              state    <= HDR_LEN;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (tmo_flag) begin
            tx_data <= ST_TMO;
            tx_stb  <= 1'b1;
            state   <= TX_STAT;
          end
        end

        HDR_LEN: begin
          if (take) begin
            len <= (len << 8) | LEN_W'(rx_data);
`ifdef UART_SDRAM_CSUM_EN
            csum <= csum ^ rx_data;
`endif
            if (byte_cnt == LEN_LAST) begin
              byte_cnt <= '0;
`ifdef UART_SDRAM_CSUM_EN
              state    <= HDR_CSUM;
`else
              state    <= CHK;
`endif
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (tmo_flag) begin
            tx_data <= ST_TMO;
            tx_stb  <= 1'b1;
            state   <= TX_STAT;
          end
        end

`ifdef UART_SDRAM_CSUM_EN
        HDR_CSUM: begin
          if (take) begin
            if (rx_data == csum) begin
              state <= CHK;
            end else begin
              tx_data <= ST_CSUM;
              tx_stb  <= 1'b1;
              state   <= TX_STAT;
            end
          end else if (tmo_flag) begin
            tx_data <= ST_TMO;
            tx_stb  <= 1'b1;
            state   <= TX_STAT;
          end
        end
`endif

        CHK: begin
          if (len == '0) begin
            tx_data <= ST_OK;
            tx_stb  <= 1'b1;
            state   <= TX_STAT;
          end else if (op_wr) begin
            byte_cnt <= '0;
            state    <= RX_DATA;
          end else begin
            sd_stb_rd <= 1'b1;
            state     <= SD_REQ;
          end
        end

        RX_DATA: begin
          if (take) begin
            sd_wdata <= (sd_wdata << 8) | DW'(rx_data);
            if (byte_cnt == DAT_LAST) begin
              sd_stb_wt <= 1'b1;
              state     <= SD_REQ;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (tmo_flag) begin
            tx_data <= ST_TMO;
            tx_stb  <= 1'b1;
            state   <= TX_STAT;
          end
        end

        // Address wraps silently at 2^ADR_W; len counts words still owed.
        SD_REQ: begin
          if (sd_ack) begin
            sd_stb_rd <= 1'b0;
            sd_stb_wt <= 1'b0;
            sd_adr    <= sd_adr + 1'b1;
            len       <= len - 1'b1;
            byte_cnt  <= '0;
            if (!op_wr) begin
              rd_shift <= sd_rdata << 8;
              tx_data  <= sd_rdata[DW-1 -: 8];
              tx_stb   <= 1'b1;
              state    <= TX_DATA;
            end else if (len == LEN_W'(1)) begin
              tx_data <= ST_OK;
              tx_stb  <= 1'b1;
              state   <= TX_STAT;
            end else begin
              state <= RX_DATA;
            end
          end
        end

        TX_DATA: begin
          if (tx_ack) begin
            if (byte_cnt == DAT_LAST) begin
              if (len == '0) begin
                tx_data <= ST_OK;
                state   <= TX_STAT;
              end else begin
                tx_stb    <= 1'b0;
                sd_stb_rd <= 1'b1;
                state     <= SD_REQ;
              end
            end else begin
              tx_data  <= rd_shift[DW-1 -: 8];
              rd_shift <= rd_shift << 8;
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        TX_STAT: begin
          if (tx_ack) begin
            tx_stb <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sdram_bridge.sv
// Directed bench for uart_sdram_bridge with a 3-cycle SDRAM responder and an auto-acking UART TX sink.
module tb_uart_sdram_bridge;
  localparam int TMO = 40;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_stb = 1'b0;
  logic        rx_ack;
  logic [7:0]  tx_data;
  logic        tx_stb;
  logic        tx_ack = 1'b0;
  logic [23:0] sd_adr;
  logic [15:0] sd_wdata;
  logic        sd_stb_rd, sd_stb_wt;
  logic        sd_ack = 1'b0;
  logic [15:0] sd_rdata = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_q[$];
  logic [23:0] wr_adr_q[$], rd_adr_q[$];
  logic [15:0] wr_dat_q[$], rd_dat_q[$];
  bit          sd_en = 1'b1, tx_en = 1'b1, stb_seen = 1'b0;
  int          sd_cnt = 0;

  uart_sdram_bridge #(.TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_stb(rx_stb), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_ack(tx_ack),
    .sd_adr(sd_adr), .sd_wdata(sd_wdata), .sd_stb_rd(sd_stb_rd), .sd_stb_wt(sd_stb_wt),
    .sd_ack(sd_ack), .sd_rdata(sd_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // SDRAM model: ack pulses on the 3rd cycle a strobe is seen, logging each access.
  initial forever begin
    @(posedge CLK); #1;
    if (sd_stb_rd || sd_stb_wt) stb_seen = 1'b1;
    if (sd_ack) begin
      sd_ack = 1'b0;
      sd_cnt = 0;
    end else if ((sd_stb_rd || sd_stb_wt) && sd_en) begin
      sd_cnt++;
      if (sd_cnt == 3) begin
        sd_ack = 1'b1;
        if (sd_stb_wt) begin
          wr_adr_q.push_back(sd_adr);
          wr_dat_q.push_back(sd_wdata);
        end else begin
          rd_adr_q.push_back(sd_adr);
          sd_rdata = (rd_dat_q.size() > 0) ? rd_dat_q.pop_front() : 16'h0000;
        end
      end
    end else begin
      sd_cnt = 0;
    end
  end

  // UART TX model: acks every presented byte one cycle later.
  initial forever begin
    @(posedge CLK); #1;
    if (tx_ack) tx_ack = 1'b0;
    else if (tx_stb && tx_en) begin
      tx_ack = 1'b1;
      tx_q.push_back(tx_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1);
  end

  task automatic clear_logs();
    tx_q.delete(); wr_adr_q.delete(); wr_dat_q.delete();
    rd_adr_q.delete(); rd_dat_q.delete();
    stb_seen = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_stb  = 1'b1;
    @(negedge CLK);
    while (!rx_ack && n < 300) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (rx_ack !== 1'b1) begin
      errors++;
      $display("FAIL rx_accept byte %h: rx_ack=%b want 1", b, rx_ack);
    end
    @(posedge CLK); #1;
    rx_stb = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] adr, input logic [15:0] ln);
    logic [7:0] b[6];
    b = '{cmd, adr[23:16], adr[15:8], adr[7:0], ln[15:8], ln[7:0]};
    foreach (b[i]) send_byte(b[i]);
`ifdef UART_SDRAM_CSUM_EN
    send_byte(b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5]);
`endif
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || tx_stb) && n < 500) begin
      @(posedge CLK); #2;
      n++;
    end
    checks++;
    if (busy !== 1'b0 || tx_stb !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b tx_stb=%b want 0 0", nm, busy, tx_stb);
    end
  endtask

  task automatic test_reset();
    logic [23:0] got[8];
    RST = 1'b1; rx_stb = 1'b1; rx_data = 8'h52;
    repeat (3) @(posedge CLK);
    #2;
    got = '{24'(rx_ack), 24'(busy), 24'(tx_stb), 24'(sd_stb_rd), 24'(sd_stb_wt),
            sd_adr, 24'(sd_wdata), 24'(tx_data)};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== 24'h0) begin
        errors++;
        $display("FAIL reset_val[%0d]: got %h want 0", i, got[i]);
      end
    end
    rx_stb = 1'b0;
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_write();
    logic [23:0] ea[2] = '{24'h000010, 24'h000011};
    logic [15:0] ed[2] = '{16'h1234, 16'hABCD};
    clear_logs();
    send_hdr(8'h57, 24'h000010, 16'h0002);
    checks++;
    if (busy !== 1'b1 || sd_stb_wt !== 1'b0) begin
      errors++;
      $display("FAIL wr_hdr: busy=%b stb_wt=%b want 1 0", busy, sd_stb_wt);
    end
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    wait_idle("wr");
    checks++;
    if (wr_adr_q.size() != 2 || rd_adr_q.size() != 0) begin
      errors++;
      $display("FAIL wr_count: writes=%0d reads=%0d want 2 0", wr_adr_q.size(), rd_adr_q.size());
    end
    while (wr_adr_q.size() < 2) begin wr_adr_q.push_back('x); wr_dat_q.push_back('x); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wr_adr_q[i] !== ea[i] || wr_dat_q[i] !== ed[i]) begin
        errors++;
        $display("FAIL wr_word[%0d]: got %h@%h want %h@%h", i, wr_dat_q[i], wr_adr_q[i], ed[i], ea[i]);
      end
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
      errors++;
      $display("FAIL wr_status: got %0d bytes first %h want 1 byte 4b", tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_read_wrap();
    logic [7:0]  et[5] = '{8'h55, 8'h55, 8'hAA, 8'hAA, 8'h4B};
    logic [23:0] ea[2] = '{24'hFFFFFF, 24'h000000};
    clear_logs();
    rd_dat_q.push_back(16'h5555);
    rd_dat_q.push_back(16'hAAAA);
    send_hdr(8'h52, 24'hFFFFFF, 16'h0002);
    wait_idle("rd");
    checks++;
    if (rd_adr_q.size() != 2 || wr_adr_q.size() != 0) begin
      errors++;
      $display("FAIL rd_count: reads=%0d writes=%0d want 2 0", rd_adr_q.size(), wr_adr_q.size());
    end
    while (rd_adr_q.size() < 2) rd_adr_q.push_back('x);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_adr_q[i] !== ea[i]) begin
        errors++;
        $display("FAIL rd_adr[%0d]: got %h want %h", i, rd_adr_q[i], ea[i]);
      end
    end
    checks++;
    if (tx_q.size() != 5) begin
      errors++;
      $display("FAIL rd_tx_count: got %0d want 5", tx_q.size());
    end
    while (tx_q.size() < 5) tx_q.push_back('x);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_q[i] !== et[i]) begin
        errors++;
        $display("FAIL rd_tx[%0d]: got %h want %h", i, tx_q[i], et[i]);
      end
    end
    checks++;
    if (sd_adr !== 24'h000001) begin
      errors++;
      $display("FAIL rd_adr_end: got %h want 000001", sd_adr);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_logs();
    send_hdr(8'h57, 24'h000020, 16'h0001);
    send_byte(8'h12);
    // Still waiting after TMO-1 idle cycles.
    repeat (TMO - 1) @(posedge CLK);
    #2;
    checks++;
    if (tx_stb !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: tx_stb=%b busy=%b want 0 1", tx_stb, busy);
    end
    while (!tx_stb && tx_q.size() == 0 && n < 4) begin
      @(posedge CLK); #2;
      n++;
    end
    checks++;
    if (!tx_stb && tx_q.size() == 0) begin
      errors++;
      $display("FAIL tmo_fire: no status byte %0d cycles after timeout, want one", n);
    end
    wait_idle("tmo");
    checks++;
    if (tx_q.size() != 1 || tx_q[0] !== 8'h45 || stb_seen) begin
      errors++;
      $display("FAIL tmo_status: bytes=%0d first=%h strobe_seen=%b want 1 45 0",
               tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, stb_seen);
    end
  endtask

  task automatic test_coincident();
    clear_logs();
    send_hdr(8'h57, 24'h000030, 16'h0001);
    send_byte(8'h5A);
    // Second byte lands in the very cycle the idle counter expires.
    repeat (TMO) @(posedge CLK);
    #1;
    send_byte(8'hA5);
    wait_idle("coin");
    checks++;
    if (wr_adr_q.size() != 1 || tx_q.size() != 1) begin
      errors++;
      $display("FAIL coin_count: writes=%0d tx=%0d want 1 1", wr_adr_q.size(), tx_q.size());
    end
    while (wr_adr_q.size() < 1) begin wr_adr_q.push_back('x); wr_dat_q.push_back('x); end
    while (tx_q.size() < 1) tx_q.push_back('x);
    checks++;
    if (wr_adr_q[0] !== 24'h000030 || wr_dat_q[0] !== 16'h5AA5 || tx_q[0] !== 8'h4B) begin
      errors++;
      $display("FAIL coin_word: got %h@%h status %h want 5aa5@000030 status 4b",
               wr_dat_q[0], wr_adr_q[0], tx_q[0]);
    end
  endtask

  task automatic test_junk_len0();
    clear_logs();
    send_byte(8'h00);
    send_byte(8'h41);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL junk_busy: got %b want 0", busy);
    end
    send_hdr(8'h52, 24'h000005, 16'h0000);
    wait_idle("len0");
    checks++;
    if (stb_seen || tx_q.size() != 1 || tx_q[0] !== 8'h4B) begin
      errors++;
      $display("FAIL len0_status: strobe_seen=%b bytes=%0d first=%h want 0 1 4b",
               stb_seen, tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx);
    end
    checks++;
    if (sd_adr !== 24'h000005) begin
      errors++;
      $display("FAIL len0_adr: got %h want 000005", sd_adr);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    sd_en = 1'b0;
    send_hdr(8'h52, 24'h000100, 16'h0002);
    while (!sd_stb_rd && n < 20) begin @(posedge CLK); #2; n++; end
    checks++;
    if (sd_stb_rd !== 1'b1) begin
      errors++;
      $display("FAIL rstA_req: sd_stb_rd=%b want 1", sd_stb_rd);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #2;
    checks++;
    if (sd_stb_rd !== 1'b0 || busy !== 1'b0 || tx_stb !== 1'b0) begin
      errors++;
      $display("FAIL rstA_drop: stb_rd=%b busy=%b tx_stb=%b want 0 0 0", sd_stb_rd, busy, tx_stb);
    end
    RST = 1'b0;
    sd_en = 1'b1;
    @(posedge CLK); #1;

    clear_logs();
    tx_en = 1'b0;
    rd_dat_q.push_back(16'h1234);
    rd_dat_q.push_back(16'h5678);
    send_hdr(8'h52, 24'h000200, 16'h0002);
    n = 0;
    while (!tx_stb && n < 40) begin @(posedge CLK); #2; n++; end
    checks++;
    if (tx_stb !== 1'b1 || tx_data !== 8'h12) begin
      errors++;
      $display("FAIL rstB_tx: tx_stb=%b tx_data=%h want 1 12", tx_stb, tx_data);
    end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #2;
    checks++;
    if (tx_stb !== 1'b0 || busy !== 1'b0 || sd_stb_rd !== 1'b0) begin
      errors++;
      $display("FAIL rstB_drop: tx_stb=%b busy=%b stb_rd=%b want 0 0 0", tx_stb, busy, sd_stb_rd);
    end
    RST = 1'b0;
    tx_en = 1'b1;
    repeat (10) @(posedge CLK);
    #2;
    checks++;
    if (tx_q.size() != 0 || busy !== 1'b0 || rd_adr_q.size() != 1) begin
      errors++;
      $display("FAIL rstB_after: tx=%0d busy=%b reads=%0d want 0 0 1", tx_q.size(), busy, rd_adr_q.size());
    end
    rd_dat_q.delete();
  endtask

`ifdef UART_SDRAM_CSUM_EN
  task automatic test_csum();
    clear_logs();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h16);
    send_byte(8'h00); send_byte(8'hFF);
    wait_idle("csum_ok");
    checks++;
    if (wr_adr_q.size() != 1 || tx_q.size() != 1) begin
      errors++;
      $display("FAIL csum_ok_count: writes=%0d tx=%0d want 1 1", wr_adr_q.size(), tx_q.size());
    end
    while (wr_adr_q.size() < 1) begin wr_adr_q.push_back('x); wr_dat_q.push_back('x); end
    while (tx_q.size() < 1) tx_q.push_back('x);
    checks++;
    if (wr_adr_q[0] !== 24'h000040 || wr_dat_q[0] !== 16'h00FF || tx_q[0] !== 8'h4B) begin
      errors++;
      $display("FAIL csum_ok_word: got %h@%h status %h want 00ff@000040 status 4b",
               wr_dat_q[0], wr_adr_q[0], tx_q[0]);
    end
    clear_logs();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    wait_idle("csum_bad");
    checks++;
    if (stb_seen || tx_q.size() != 1 || tx_q[0] !== 8'h4E) begin
      errors++;
      $display("FAIL csum_bad: strobe_seen=%b bytes=%0d first=%h want 0 1 4e",
               stb_seen, tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read_wrap();
    test_timeout();
    test_coincident();
    test_junk_len0();
    test_reset_mid();
`ifdef UART_SDRAM_CSUM_EN
    test_csum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
